pwm_sequencer: RTL and testbench

Run-time controller for the two-switch dead-time PWM datapath. It sequences soft-start, slew-limited duty changes, controlled shutdown and fault lockout. It also supplies the datapath's period count (maxcount), duty count and both dead-time codes, committing new values only at PWM period boundaries. It sits between the switch/host configuration inputs and the counter/dead-time generators, and gates the GPIO drive through `gate_en`.

---
 rtl/pwm_pkg.sv | 45 ++++
 rtl/duty_slew.sv | 87 ++++++++
 rtl/pwm_sequencer.sv | 152 +++++++++++++++
 tb/tb_pwm_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM sequencer: state encoding, duty-register commands, frequency table.
// Purely declarative; no latency and no flow control.
package pwm_pkg;

  localparam int DUTY_MIN_DEF    = 2;
  localparam int DUTY_MARGIN_DEF = 4;
  localparam int MC_W            = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_STOP  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    SLEW_HOLD     = 3'd0,
    SLEW_CLEAR    = 3'd1,
    SLEW_LOAD_MIN = 3'd2,
    SLEW_TOWARD   = 3'd3,
    SLEW_DEC      = 3'd4
  } slew_cmd_e;

  // Period counts for the 50 MHz clock; unused codes fall back to the slowest setting.
  function automatic logic [MC_W-1:0] freq_to_maxcount(input logic [3:0] sel);
    logic [MC_W-1:0] mc;
    case (sel)
      4'd1:    mc = 10'd769;
      4'd2:    mc = 10'd625;
      4'd3:    mc = 10'd526;
      4'd4:    mc = 10'd455;
      4'd5:    mc = 10'd400;
      4'd6:    mc = 10'd357;
      4'd7:    mc = 10'd322;
      4'd8:    mc = 10'd294;
      4'd9:    mc = 10'd270;
      4'd10:   mc = 10'd250;
      default: mc = 10'd1000;
    endcase
    return mc;
  endfunction

endpackage

// File: rtl/duty_slew.sv
// Duty register with slew-limited step toward a clamped target, shutdown decrement and ceiling snap.
// Latency: 1 cycle (registered duty); no backpressure, the sequencer issues one command per cycle.
module duty_slew
  import pwm_pkg::*;
#(
  parameter int CW       = 10,
  parameter int DUTY_MIN = DUTY_MIN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  slew_cmd_e     cmd_i,
  input  logic [CW-1:0] target_i,
  input  logic [CW-1:0] ceil_i,
  input  logic [3:0]    step_i,
  output logic [CW-1:0] duty_o,
  output logic          at_lim_o,
  output logic          dec_uf_o
);

  localparam logic [CW-1:0] MIN_C = CW'(DUTY_MIN);
  localparam logic [CW:0]   MIN_W = (CW+1)'(DUTY_MIN);

  logic [CW-1:0] duty_q, duty_d;
  logic [CW-1:0] lim, toward, dec;
  logic [CW:0]   step_w, duty_w, lim_w, up_w, dn_w;
  logic          dec_uf;

  // All adds and subtracts run one bit wider so the comparisons below saturate instead of wrapping.
  always_comb begin
    step_w = (step_i == 4'd0) ? (CW+1)'(1) : (CW+1)'(step_i);
    duty_w = {1'b0, duty_q};

    if (target_i < MIN_C) begin
      lim = MIN_C;
    end else if (target_i > ceil_i) begin
      lim = ceil_i;
    end else begin
      lim = target_i;
    end
    lim_w = {1'b0, lim};

    up_w = duty_w + step_w;
    dn_w = duty_w - step_w;

    toward = duty_q;
    if (duty_q > ceil_i) begin
      toward = ceil_i;
    end else if (duty_q < lim) begin
      toward = (up_w > lim_w) ? lim : up_w[CW-1:0];
    end else if (duty_q > lim) begin
      toward = (duty_w >= lim_w + step_w) ? dn_w[CW-1:0] : lim;
    end

    dec_uf = 1'b0;
    dec    = dn_w[CW-1:0];
    if (duty_q > ceil_i) begin
      dec = ceil_i;
    end else if (duty_w < MIN_W + step_w) begin
      dec_uf = 1'b1;
      dec    = '0;
    end
  end

  always_comb begin
    duty_d = duty_q;
    case (cmd_i)
      SLEW_CLEAR:    duty_d = '0;
      SLEW_LOAD_MIN: duty_d = MIN_C;
      SLEW_TOWARD:   duty_d = toward;
      SLEW_DEC:      duty_d = dec;
      default:       duty_d = duty_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty_o   = duty_q;
  assign at_lim_o = (toward == lim);
  assign dec_uf_o = dec_uf;

endmodule

// File: rtl/pwm_sequencer.sv
// Run-time PWM controller: soft-start, slewed duty, controlled stop and fault lockout, committed at period boundaries.
// Latency: 1 cycle from any input to the registered outputs; no backpressure, updates are paced by period_start.
module pwm_sequencer
  import pwm_pkg::*;
#(
  parameter int CW          = 10,
  parameter int DTW         = 3,
  parameter int DUTY_MIN    = DUTY_MIN_DEF,
  parameter int DUTY_MARGIN = DUTY_MARGIN_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           fault,
  input  logic           period_start,
  input  logic [3:0]     freq_sel,
  input  logic [CW-1:0]  duty_target,
  input  logic [3:0]     ramp_step,
  input  logic [DTW-1:0] dt1_in,
  input  logic [DTW-1:0] dt2_in,
  output logic [CW-1:0]  maxcount_o,
  output logic [CW-1:0]  duty_o,
  output logic [DTW-1:0] dt1_o,
  output logic [DTW-1:0] dt2_o,
  output logic           gate_en,
  output logic [2:0]     state_o,
  output logic           fault_latched
);

  localparam logic [CW-1:0] MC_RST = CW'(1000);

  state_e         state_q, state_d;
  slew_cmd_e      cmd;
  logic [CW-1:0]  maxcount_q, maxcount_d, ceil;
  logic [DTW-1:0] dt1_q, dt1_d, dt2_q, dt2_d;
  logic           gate_q, gate_d;
  logic           flt_q, flt_d;
  logic           at_lim, dec_uf;

  // The ceiling always tracks the maxcount being committed on this edge, so a frequency change snaps duty at once.
  always_comb begin
    maxcount_d = period_start ? CW'(freq_to_maxcount(freq_sel)) : maxcount_q;
    dt1_d      = period_start ? dt1_in : dt1_q;
    dt2_d      = period_start ? dt2_in : dt2_q;
    ceil       = maxcount_d - CW'(DUTY_MARGIN);
  end

  duty_slew #(
    .CW       (CW),
    .DUTY_MIN (DUTY_MIN)
  ) u_slew (
    .clk      (clk),
    .rst      (rst),
    .cmd_i    (cmd),
    .target_i (duty_target),
    .ceil_i   (ceil),
    .step_i   (ramp_step),
    .duty_o   (duty_o),
    .at_lim_o (at_lim),
    .dec_uf_o (dec_uf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) state_d = ST_ARM;
        end
        ST_ARM: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (period_start) begin
            state_d = ST_RAMP;
          end
        end
        ST_RAMP, ST_RUN: begin
          if (!enable) begin
            state_d = (period_start && dec_uf) ? ST_IDLE : ST_STOP;
          end else if (period_start && at_lim && state_q == ST_RAMP) begin
            state_d = ST_RUN;
          end
        end
        ST_STOP: begin
          if (enable) begin
            state_d = (period_start && at_lim) ? ST_RUN : ST_RAMP;
          end else if (period_start && dec_uf) begin
            state_d = ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (!enable) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd    = SLEW_HOLD;
    flt_d  = flt_q | fault;
    gate_d = (state_d == ST_RAMP) || (state_d == ST_RUN) || (state_d == ST_STOP);
    if (fault) begin
      cmd = SLEW_CLEAR;
    end else begin
      case (state_q)
        ST_IDLE, ST_FAULT: cmd = SLEW_CLEAR;
        ST_ARM: begin
          if (enable && period_start) cmd = SLEW_LOAD_MIN;
        end
        ST_RAMP, ST_RUN, ST_STOP: begin
          if (period_start) cmd = enable ? SLEW_TOWARD : SLEW_DEC;
        end
        default: cmd = SLEW_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maxcount_q <= MC_RST;
      dt1_q      <= '0;
      dt2_q      <= '0;
      gate_q     <= 1'b0;
      flt_q      <= 1'b0;
    end else begin
      maxcount_q <= maxcount_d;
      dt1_q      <= dt1_d;
      dt2_q      <= dt2_d;
      gate_q     <= gate_d;
      flt_q      <= flt_d;
    end
  end

  assign maxcount_o    = maxcount_q;
  assign dt1_o         = dt1_q;
  assign dt2_o         = dt2_q;
  assign gate_en       = gate_q;
  assign state_o       = state_q;
  assign fault_latched = flt_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Randomized bench for pwm_sequencer: directed scenarios plus a random soak, all checked cycle by cycle
// against an integer-arithmetic model of the sequencing rules.
module tb_pwm_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, fault, period_start;
  logic [3:0] freq_sel, ramp_step;
  logic [9:0] duty_target;
  logic [2:0] dt1_in, dt2_in;
  logic [9:0] maxcount_o, duty_o;
  logic [2:0] dt1_o, dt2_o;
  logic       gate_en;
  logic [2:0] state_o;
  logic       fault_latched;

  int n_chk  = 0;
  int n_pass = 0;
  int ps_gap = 0;

  int m_state, m_duty, m_max, m_dt1, m_dt2, m_gate, m_latch;

  always #5 clk = ~clk;

  pwm_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .fault         (fault),
    .period_start  (period_start),
    .freq_sel      (freq_sel),
    .duty_target   (duty_target),
    .ramp_step     (ramp_step),
    .dt1_in        (dt1_in),
    .dt2_in        (dt2_in),
    .maxcount_o    (maxcount_o),
    .duty_o        (duty_o),
    .dt1_o         (dt1_o),
    .dt2_o         (dt2_o),
    .gate_en       (gate_en),
    .state_o       (state_o),
    .fault_latched (fault_latched)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int tbl(input int sel);
    int t[11] = '{1000, 769, 625, 526, 455, 400, 357, 322, 294, 270, 250};
    return (sel <= 10) ? t[sel] : 1000;
  endfunction

  function automatic int toward(input int d, input int lim, input int stp, input int ceil);
    if (d > ceil) return ceil;
    if (d < lim) return (d + stp > lim) ? lim : d + stp;
    if (d > lim) return (d - stp < lim) ? lim : d - stp;
    return d;
  endfunction

  task automatic model_reset();
    m_state = 0; m_duty = 0; m_max = 1000;
    m_dt1 = 0; m_dt2 = 0; m_gate = 0; m_latch = 0;
  endtask

  task automatic model_step();
    int stp, nmax, ceil, lim, ns, nd;
    stp  = (ramp_step == 4'd0) ? 1 : int'(ramp_step);
    nmax = period_start ? tbl(int'(freq_sel)) : m_max;
    ceil = nmax - 4;
    lim  = int'(duty_target);
    if (lim < 2) lim = 2;
    if (lim > ceil) lim = ceil;
    ns = m_state;
    nd = m_duty;
    if (fault) begin
      ns = 5; nd = 0; m_latch = 1;
    end else begin
      case (m_state)
        0: begin nd = 0; if (enable) ns = 1; end
        1: begin
          if (!enable) ns = 0;
          else if (period_start) begin nd = 2; ns = 2; end
        end
        2, 3, 4: begin
          if (enable) begin
            if (m_state == 4) ns = 2;
            if (period_start) begin
              nd = toward(m_duty, lim, stp, ceil);
              if (ns == 2 && nd == lim) ns = 3;
            end
          end else begin
            ns = 4;
            if (period_start) begin
              if (m_duty > ceil) nd = ceil;
              else if (m_duty - stp < 2) begin nd = 0; ns = 0; end
              else nd = m_duty - stp;
            end
          end
        end
        default: begin nd = 0; if (!enable) ns = 0; end
      endcase
    end
    if (period_start) begin
      m_max = nmax; m_dt1 = int'(dt1_in); m_dt2 = int'(dt2_in);
    end
    m_state = ns;
    m_duty  = nd;
    m_gate  = (ns >= 2 && ns <= 4) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("state", int'(state_o), m_state);
    check("duty", int'(duty_o), m_duty);
    check("maxcount", int'(maxcount_o), m_max);
    check("dt1", int'(dt1_o), m_dt1);
    check("dt2", int'(dt2_o), m_dt2);
    check("gate_en", int'(gate_en), m_gate);
    check("fault_latched", int'(fault_latched), m_latch);
  endtask

  // One clock: pace period_start with a random gap, clock, advance the model, compare after the edge.
  task automatic tick();
    if (ps_gap == 0) begin
      period_start = 1'b1;
      ps_gap = $urandom_range(2, 5);
    end else begin
      period_start = 1'b0;
      ps_gap--;
    end
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, int'(state_o), 0);
    check({tag, "_maxcount"}, int'(maxcount_o), 1000);
    check({tag, "_duty"}, int'(duty_o), 0);
    check({tag, "_dt"}, int'({dt1_o, dt2_o}), 0);
    check({tag, "_gate"}, int'(gate_en), 0);
    check({tag, "_latch"}, int'(fault_latched), 0);
  endtask

  task automatic run_until_state(input string tag, input int st, input int budget);
    int n = 0;
    while (m_state != st && n < budget) begin tick(); n++; end
    check({tag, "_timeout"}, (m_state != st) ? 1 : 0, 0);
  endtask

  task automatic wait_ps(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!period_start && n < 12);
    check({tag, "_ps_timeout"}, period_start ? 0 : 1, 0);
  endtask

  initial begin
    int cnt, prev, maxobs, n;
    int shut_exp[3] = '{12, 4, 0};

    rst = 1'b1; enable = 1'b0; fault = 1'b0; period_start = 1'b0;
    freq_sel = 4'd0; ramp_step = 4'd8; duty_target = 10'd400;
    dt1_in = 3'd0; dt2_in = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Soft-start: 51 period boundaries from ARM (2, 10, ... 394, 400)
    enable = 1'b1;
    cnt = 0; n = 0;
    while (m_state != 3 && n < 600) begin
      prev = m_state;
      dt1_in = 3'($urandom); dt2_in = 3'($urandom);
      tick();
      if (period_start && (prev == 1 || prev == 2)) cnt++;
      n++;
    end
    check("ss_timeout", (m_state != 3) ? 1 : 0, 0);
    check("ss_periods", cnt, 51);
    check("ss_run_duty", int'(duty_o), 400);

    // Frequency change while running at 500: duty snaps to 455-4 on the reload
    duty_target = 10'd500;
    n = 0;
    while (m_duty != 500 && n < 400) begin tick(); n++; end
    check("fc_reach500", int'(duty_o), 500);
    freq_sel = 4'd4;
    wait_ps("fc");
    check("fc_maxcount", int'(maxcount_o), 455);
    check("fc_duty", int'(duty_o), 451);
    check("fc_state", int'(state_o), 3);

    // Shutdown from duty 20 with step 8
    duty_target = 10'd20;
    n = 0;
    while (m_duty != 20 && n < 800) begin tick(); n++; end
    check("sd_reach20", int'(duty_o), 20);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_ps("sd");
      check("sd_duty", int'(duty_o), shut_exp[i]);
    end
    check("sd_gate", int'(gate_en), 0);
    check("sd_state", int'(state_o), 0);

    // Clamp at the fastest frequency: ceiling 246
    freq_sel = 4'd10; duty_target = 10'd300; enable = 1'b1;
    maxobs = 0; n = 0;
    while ((m_state != 3 || n < 200) && n < 800) begin
      tick();
      if (int'(duty_o) > maxobs) maxobs = int'(duty_o);
      n++;
    end
    check("clamp_state", int'(state_o), 3);
    check("clamp_duty", int'(duty_o), 246);
    check("clamp_never_above", (maxobs > 246) ? 1 : 0, 0);

    // Fault during RAMP, lockout until enable drops
    enable = 1'b0;
    run_until_state("ft_idle", 0, 1000);
    freq_sel = 4'd0; duty_target = 10'd400; enable = 1'b1;
    run_until_state("ft_ramp", 2, 50);
    repeat (3) tick();
    fault = 1'b1;
    tick();
    fault = 1'b0;
    check("ft_gate", int'(gate_en), 0);
    check("ft_latch", int'(fault_latched), 1);
    check("ft_state", int'(state_o), 5);
    repeat (6) tick();
    check("ft_hold", int'(state_o), 5);
    enable = 1'b0;
    tick();
    check("ft_exit", int'(state_o), 0);
    check("ft_sticky", int'(fault_latched), 1);

    // Random soak
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      fault = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) duty_target = 10'($urandom);
      if ($urandom_range(0, 29) == 0) ramp_step = 4'($urandom);
      if ($urandom_range(0, 99) == 0) freq_sel = 4'($urandom);
      dt1_in = 3'($urandom); dt2_in = 3'($urandom);
      tick();
    end

    // Asynchronous reset in RUN
    fault = 1'b0; enable = 1'b0; ramp_step = 4'd15;
    run_until_state("rs_idle", 0, 2000);
    freq_sel = 4'($urandom_range(0, 10));
    duty_target = 10'($urandom_range(50, 240));
    enable = 1'b1;
    run_until_state("rs_run", 3, 600);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    enable = 1'b0;
    #2;
    rst = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
